// File: rtl/rr_arb_8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
//   N_REQ / IDX_W : number of requesters and width of a requester index
//   HOLD_W        : width of the grant hold counter
//   state_t       : arbiter FSM state encoding
//   rr_pick       : circular first-set search starting at a pointer
package rr_arb_8_pkg;

  localparam int N_REQ  = 8;
  localparam int IDX_W  = 3;
  localparam int HOLD_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Returns the first set bit of req in the order ptr, ptr+1, ... ptr+7
  // (mod 8). Scanning offsets from high to low lets the lowest offset win
  // without a separate "found" flag. Result is ptr when req is all-zero;
  // callers only use it when req is non-zero.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [N_REQ-1:0] req,
    input logic [IDX_W-1:0] ptr
  );
    logic [IDX_W-1:0] idx;
    rr_pick = ptr;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      idx = ptr + off[IDX_W-1:0];
      if (req[idx]) begin
        rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/rr_arb_8_dec.sv
// 3-to-8 one-hot decoder.
//   a : binary index in
//   l : one-hot out, bit a set
module dec_3to8 (
  input  logic [2:0] a,
  output logic [7:0] l
);

  for (genvar gi = 0; gi < 8; gi++) begin : g_dec
    assign l[gi] = (a == 3'(gi));
  end

endmodule

// File: rtl/rr_arb_8.sv
// Round-robin arbiter sharing one resource between 8 requesters.
// A grant is held while its request stays high, up to HOLD_MAX cycles
// (0 = unlimited), and every grant is followed by exactly one dead cycle.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   req       : level-sensitive request vector, bit i = requester i
//   gnt       : one-hot grant, all-zero when no grant is active
//   gnt_idx   : registered index of the grantee, holds when idle
//   gnt_valid : a grant is active
//   timeout   : one-cycle pulse in the cycle after a forced release
module rr_arb_8
  import rr_arb_8_pkg::*;
#(
  parameter logic [HOLD_W-1:0] HOLD_MAX = 8'd15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic                valid_reg, valid_next;
  logic [IDX_W-1:0]    ptr_reg, ptr_next;
  logic [HOLD_W-1:0]   cnt_reg, cnt_next;
  logic                timeout_reg, timeout_next;
  logic                hold_hit;
  logic                req_cur;
  logic [N_REQ-1:0]    dec_l;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      valid_reg   <= 1'b0;
      ptr_reg     <= '0;
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      valid_reg   <= valid_next;
      ptr_reg     <= ptr_next;
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  // cnt_reg counts completed cycles of the current grant minus one, so the
  // grant is released after exactly HOLD_MAX valid cycles.
  assign hold_hit = (HOLD_MAX != '0) && (cnt_reg == HOLD_MAX - 8'd1);
  assign req_cur  = req[idx_reg];

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    valid_next   = valid_reg;
    ptr_next     = ptr_reg;
    cnt_next     = cnt_reg;
    timeout_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req != '0) begin
          idx_next   = rr_pick(req, ptr_reg);
          valid_next = 1'b1;
          cnt_next   = '0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (!req_cur || hold_hit) begin
          valid_next   = 1'b0;
          ptr_next     = idx_reg + 3'd1;
          state_next   = IDLE;
          // A withdrawn request is a normal release even if the limit
          // happened to be reached in the same cycle.
          timeout_next = req_cur;
        end else if (cnt_reg != '1) begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  dec_3to8 u_dec (
    .a (idx_reg),
    .l (dec_l)
  );

  assign gnt       = dec_l & {N_REQ{valid_reg}};
  assign gnt_idx   = idx_reg;
  assign gnt_valid = valid_reg;
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_rr_arb_8.sv
// Bench for rr_arb_8: three instances (HOLD_MAX = 0, 2, 4) share one
// stimulus; a cycle-level model per instance is checked every clock and
// directed literal expectations pin specific scenarios.
module tb_rr_arb_8;

  logic       clk;
  logic       rst;
  logic [7:0] req;

  logic [7:0] gnt0, gnt1, gnt2;
  logic [2:0] idx0, idx1, idx2;
  logic       v0, v1, v2;
  logic       to0, to1, to2;

  int total = 0;
  int bad   = 0;

  rr_arb_8 #(.HOLD_MAX(8'd0)) dut0 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(v0), .timeout(to0)
  );
  rr_arb_8 #(.HOLD_MAX(8'd2)) dut1 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt1), .gnt_idx(idx1), .gnt_valid(v1), .timeout(to1)
  );
  rr_arb_8 #(.HOLD_MAX(8'd4)) dut2 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt2), .gnt_idx(idx2), .gnt_valid(v2), .timeout(to2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Model: which requester owns the resource, how many cycles it has been
  // valid, where the next search starts, and whether a forced release
  // just happened.
  int   hm     [3] = '{0, 2, 4};
  int   m_busy [3];
  int   m_idx  [3];
  int   m_ptr  [3];
  int   m_held [3];
  int   m_to   [3];
  bit   armed = 0;
  logic [7:0] r;
  logic [7:0] act_gnt [3];
  logic [2:0] act_idx [3];
  logic       act_v   [3];
  logic       act_to  [3];

  always @(posedge clk) begin
    r = req;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_busy[k] = 0; m_idx[k] = 0; m_ptr[k] = 0; m_held[k] = 0; m_to[k] = 0;
      end else if (m_busy[k] != 0) begin
        if (!r[m_idx[k]]) begin
          m_busy[k] = 0; m_ptr[k] = (m_idx[k] + 1) % 8; m_to[k] = 0;
        end else if (hm[k] != 0 && m_held[k] == hm[k]) begin
          m_busy[k] = 0; m_ptr[k] = (m_idx[k] + 1) % 8; m_to[k] = 1;
        end else begin
          m_held[k] = m_held[k] + 1; m_to[k] = 0;
        end
      end else begin
        m_to[k] = 0;
        if (r != 8'h00) begin
          for (int off = 7; off >= 0; off--) begin
            if (r[(m_ptr[k] + off) % 8]) m_idx[k] = (m_ptr[k] + off) % 8;
          end
          m_busy[k] = 1;
          m_held[k] = 1;
          $display("inst %0d grant idx %0d req %02h", k, m_idx[k], r);
        end
      end
    end
    if (rst) armed = 1;
    #1;
    act_gnt[0] = gnt0; act_gnt[1] = gnt1; act_gnt[2] = gnt2;
    act_idx[0] = idx0; act_idx[1] = idx1; act_idx[2] = idx2;
    act_v[0]   = v0;   act_v[1]   = v1;   act_v[2]   = v2;
    act_to[0]  = to0;  act_to[1]  = to1;  act_to[2]  = to2;
    if (armed) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("model_gnt%0d", k), 32'(act_gnt[k]),
            (m_busy[k] != 0) ? (32'd1 << m_idx[k]) : 32'd0);
        chk($sformatf("model_idx%0d", k), 32'(act_idx[k]), 32'(m_idx[k]));
        chk($sformatf("model_valid%0d", k), 32'(act_v[k]), 32'(m_busy[k] != 0));
        chk($sformatf("model_timeout%0d", k), 32'(act_to[k]), 32'(m_to[k]));
      end
    end
  end

  logic [7:0] e;

  initial begin
    rst = 1'b1;
    req = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt0), 32'h00);
    chk("rst_idx", 32'(idx0), 32'd0);
    chk("rst_valid", 32'(v0), 32'd0);
    chk("rst_timeout", 32'(to0), 32'd0);
    rst = 1'b0;

    // No requests: nothing granted.
    repeat (10) @(negedge clk);
    chk("idle_gnt", 32'(gnt0), 32'h00);
    chk("idle_idx", 32'(idx0), 32'd0);

    // Two requesters, unlimited hold, requester 0 drops.
    req = 8'h81;
    @(negedge clk); chk("p81_c1", 32'(gnt0), 32'h01);
    @(negedge clk); chk("p81_c2", 32'(gnt0), 32'h01);
    @(negedge clk); chk("p81_c3", 32'(gnt0), 32'h01);
    req = 8'h80;
    @(negedge clk); chk("p81_dead", 32'(gnt0), 32'h00);
    @(negedge clk); chk("p81_g7", 32'(gnt0), 32'h80);
    req = 8'h00;
    @(negedge clk); chk("p81_rel", 32'(gnt0), 32'h00);
    req = 8'hC0;   // ptr must be 0 now, so 6 wins over 7
    @(negedge clk); chk("ptr_wrap0", 32'(gnt0), 32'h40);
    req = 8'h00;
    repeat (3) @(negedge clk);

    // All requesting, HOLD_MAX=2: strict rotation with timeouts.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      e = 8'd1 << (g % 8);
      @(negedge clk); chk($sformatf("rot%0d_a", g), 32'(gnt1), 32'(e));
      @(negedge clk); chk($sformatf("rot%0d_b", g), 32'(gnt1), 32'(e));
      @(negedge clk); chk($sformatf("rot%0d_dead", g), 32'(gnt1), 32'h00);
      chk($sformatf("rot%0d_to", g), 32'(to1), 32'd1);
    end
    req = 8'h00;
    repeat (3) @(negedge clk);

    // Sole requester 5, HOLD_MAX=4: timeout then regrant.
    req = 8'h20;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); chk($sformatf("solo_c%0d", c), 32'(gnt2), 32'h20);
    end
    @(negedge clk);
    chk("solo_dead", 32'(gnt2), 32'h00);
    chk("solo_to", 32'(to2), 32'd1);
    @(negedge clk); chk("solo_regrant", 32'(gnt2), 32'h20);

    // Release of idx 5 leaves ptr=6: 0 is found before 3.
    req = 8'h09;
    @(negedge clk); chk("wrap_dead1", 32'(gnt2), 32'h00);
    @(negedge clk); chk("wrap_g0", 32'(gnt2), 32'h01);
    req = 8'h08;
    @(negedge clk); chk("wrap_dead2", 32'(gnt2), 32'h00);
    @(negedge clk); chk("wrap_g3", 32'(gnt2), 32'h08);
    req = 8'h00;
    repeat (3) @(negedge clk);

    // Reset in the middle of a grant.
    req = 8'h10;
    @(negedge clk); chk("mid_g4", 32'(gnt0), 32'h10);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_gnt", 32'(gnt0), 32'h00);
    chk("mid_rst_idx", 32'(idx0), 32'd0);
    rst = 1'b0;
    req = 8'h30;   // search restarts at 0, so 4 beats 5
    @(negedge clk); chk("mid_after", 32'(gnt0), 32'h10);
    req = 8'h00;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
